booth_r8_seq_mult: RTL and testbench

//  Sequential radix-8 Booth multiplier for the brightness path: pixel (in_a) x gain (in_b).

---
 rtl/booth_pkg.sv | 22 ++
 rtl/booth_r8_enc.sv | 21 ++
 rtl/booth_r8_seq_mult.sv | 157 +++++++++++++++
 tb/tb_booth_r8_seq_mult.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/booth_pkg.sv
// Shared definitions for the radix-8 Booth sequential multiplier: FSM states,
// recoded-digit field layout and digit-count helper.
package booth_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PRE  = 2'd1,
        ITER = 2'd2,
        DONE = 2'd3
    } state_t;

    // sel = {neg, mag[2:0]}
    localparam int SEL_NEG    = 3;
    localparam int SEL_MAG_HI = 2;
    localparam int SEL_MAG_LO = 0;

    // Radix-8 digits needed to cover an extended multiplier of bx_w bits.
    function automatic int n_dig(input int bx_w);
        return (bx_w + 2) / 3;
    endfunction

endpackage

// File: rtl/booth_r8_enc.sv
// Radix-8 Booth recoder: 4-bit overlapping multiplier window -> {neg, magnitude}.
module booth_r8_enc (
    input  logic [3:0] win,
    output logic [3:0] sel
);
    always_comb begin
        sel = 4'b0000;
        unique case (win)
            4'b0000, 4'b1111: sel = 4'b0000;
            4'b0001, 4'b0010: sel = 4'b0001;
            4'b0011, 4'b0100: sel = 4'b0010;
            4'b0101, 4'b0110: sel = 4'b0011;
            4'b0111:          sel = 4'b0100;
            4'b1000:          sel = 4'b1100;
            4'b1001, 4'b1010: sel = 4'b1011;
            4'b1011, 4'b1100: sel = 4'b1010;
            4'b1101, 4'b1110: sel = 4'b1001;
            default:          sel = 4'b0000;
        endcase
    end
endmodule

// File: rtl/booth_r8_seq_mult.sv
// Sequential radix-8 Booth multiplier (pixel x gain), one digit per cycle MSB-first,
// returning the full product plus a rounded, clamped pixel.
module booth_r8_seq_mult
    import booth_pkg::*;
#(
    parameter int A_W    = 8,
    parameter int B_W    = 8,
    parameter int FRAC_W = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [A_W-1:0] in_a,
    input  logic [B_W-1:0] in_b,
    input  logic           in_signed,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [A_W+B_W-1:0] out_prod,
    output logic [A_W-1:0] out_pix
);
    localparam int P_W   = A_W + B_W;
    localparam int AX    = A_W + 1;
    localparam int BX    = B_W + 1;
    localparam int N_DIG = n_dig(BX);
    localparam int BXE   = 3 * N_DIG;
    localparam int ACC_W = AX + BXE + 1;
    localparam int CNT_W = (N_DIG > 1) ? $clog2(N_DIG) : 1;
    localparam logic [CNT_W-1:0]     LAST_IDX = CNT_W'(N_DIG - 1);
    localparam logic signed [ACC_W:0] HALF    = (ACC_W+1)'((1 << FRAC_W) >> 1);
    localparam logic signed [ACC_W:0] PIX_MAX = (ACC_W+1)'((1 << A_W) - 1);

    state_t                   state_q, state_d;
    logic                     in_ready_q, in_ready_d;
    logic                     out_valid_q, out_valid_d;
    logic [AX-1:0]            a_x_q, a_x_d;
    logic [BXE:0]             bx_q, bx_d;
    logic signed [AX+1:0]     a3_q, a3_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic [CNT_W-1:0]         idx_q, idx_d;
    logic                     fin_q, fin_d;
    logic [P_W-1:0]           out_prod_q, out_prod_d;
    logic [A_W-1:0]           out_pix_q, out_pix_d;

    logic signed [BX-1:0]     b_x;
    logic signed [AX+1:0]     a_x_w;
    logic [3:0]               win, sel;
    logic signed [ACC_W-1:0]  ax_e, m, acc_step;
    logic signed [ACC_W:0]    rnd, shf;
    logic [A_W-1:0]           pix;

    assign b_x   = {in_signed & in_b[B_W-1], in_b};
    assign a_x_w = (AX+2)'($signed(a_x_q));
    // Window {B[3i+2:3i], B[3i-1]} is bits [3i+3:3i] once a zero sits below the LSB.
    assign win   = 4'(bx_q >> (3 * int'(idx_q)));

    booth_r8_enc u_enc (.win(win), .sel(sel));

    always_comb begin
        state_d     = state_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        a_x_d       = a_x_q;
        bx_d        = bx_q;
        a3_d        = a3_q;
        acc_d       = acc_q;
        idx_d       = idx_q;
        fin_d       = fin_q;
        out_prod_d  = out_prod_q;
        out_pix_d   = out_pix_q;

        ax_e = ACC_W'($signed(a_x_q));
        unique case (sel[SEL_MAG_HI:SEL_MAG_LO])
            3'd1:    m = ax_e;
            3'd2:    m = ax_e <<< 1;
            3'd3:    m = ACC_W'(a3_q);
            3'd4:    m = ax_e <<< 2;
            default: m = '0;
        endcase
        acc_step = (acc_q <<< 3) + (sel[SEL_NEG] ? -m : m);

        rnd = (ACC_W+1)'(acc_q) + HALF;
        shf = rnd >>> FRAC_W;
        if (shf < 0)             pix = '0;
        else if (shf > PIX_MAX)  pix = '1;
        else                     pix = shf[A_W-1:0];

        unique case (state_q)
            IDLE: if (in_valid) begin
                a_x_d      = {in_signed & in_a[A_W-1], in_a};
                bx_d       = {BXE'(b_x), 1'b0};
                in_ready_d = 1'b0;
                state_d    = PRE;
            end
            PRE: begin
                a3_d    = a_x_w + (a_x_w <<< 1);
                acc_d   = '0;
                idx_d   = LAST_IDX;
                fin_d   = 1'b0;
                state_d = ITER;
            end
            ITER: begin
                // Extra cycle after digit 0 so round/clamp reads the registered accumulator.
                if (fin_q) begin
                    out_prod_d  = acc_q[P_W-1:0];
                    out_pix_d   = pix;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end else begin
                    acc_d = acc_step;
                    if (idx_q == '0) fin_d = 1'b1;
                    else             idx_d = idx_q - 1'b1;
                end
            end
            DONE: if (out_ready) begin
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            a_x_q       <= '0;
            bx_q        <= '0;
            a3_q        <= '0;
            acc_q       <= '0;
            idx_q       <= '0;
            fin_q       <= 1'b0;
            out_prod_q  <= '0;
            out_pix_q   <= '0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            a_x_q       <= a_x_d;
            bx_q        <= bx_d;
            a3_q        <= a3_d;
            acc_q       <= acc_d;
            idx_q       <= idx_d;
            fin_q       <= fin_d;
            out_prod_q  <= out_prod_d;
            out_pix_q   <= out_pix_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_prod  = out_prod_q;
    assign out_pix   = out_pix_q;

endmodule

// File: tb/tb_booth_r8_seq_mult.sv
// Bench for booth_r8_seq_mult: directed table, backpressure/reset sequences and
// randomized ops on two parameterizations against an arithmetic reference model.
module tb_booth_r8_seq_mult;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic v0 = 0, r0, s0 = 0, ov0, or0 = 0;
    logic [7:0]  a0 = 0, b0 = 0, x0;
    logic [15:0] p0;
    logic v1 = 0, r1, s1 = 0, ov1, or1 = 0;
    logic [11:0] a1 = 0, x1;
    logic [9:0]  b1 = 0;
    logic [21:0] p1;

    booth_r8_seq_mult #(.A_W(8), .B_W(8), .FRAC_W(4)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(v0), .in_ready(r0), .in_a(a0), .in_b(b0),
        .in_signed(s0), .out_valid(ov0), .out_ready(or0), .out_prod(p0), .out_pix(x0));

    booth_r8_seq_mult #(.A_W(12), .B_W(10), .FRAC_W(6)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(v1), .in_ready(r1), .in_a(a1), .in_b(b1),
        .in_signed(s1), .out_valid(ov1), .out_ready(or1), .out_prod(p1), .out_pix(x1));

    int errs = 0;
    int checks = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: plain integer multiply, round-half-up division by 2^fw, clamp.
    function automatic void model(input int aw, input int bw, input int fw,
                                  input longint a, input longint b, input bit sgn,
                                  output longint prod, output longint pix);
        longint av, bv, p, r, mx;
        av = (sgn && a[aw-1]) ? a - (longint'(1) << aw) : a;
        bv = (sgn && b[bw-1]) ? b - (longint'(1) << bw) : b;
        p  = av * bv;
        prod = p & ((longint'(1) << (aw + bw)) - 1);
        r  = (p + ((longint'(1) << fw) >> 1)) >>> fw;
        mx = (longint'(1) << aw) - 1;
        pix = (r < 0) ? 0 : ((r > mx) ? mx : r);
    endfunction

    function automatic bit get_r(input bit w);  return w ? r1 : r0;  endfunction
    function automatic bit get_ov(input bit w); return w ? ov1 : ov0; endfunction
    function automatic longint get_p(input bit w); return w ? longint'(p1) : longint'(p0); endfunction
    function automatic longint get_x(input bit w); return w ? longint'(x1) : longint'(x0); endfunction

    task automatic set_in(input bit w, input bit v, input longint a, input longint b, input bit s);
        if (w) begin v1 = v; a1 = a[11:0]; b1 = b[9:0]; s1 = s; end
        else   begin v0 = v; a0 = a[7:0];  b0 = b[7:0]; s0 = s; end
    endtask

    task automatic set_ordy(input bit w, input bit r);
        if (w) or1 = r; else or0 = r;
    endtask

    // One full transaction; returns captured outputs and edges from handshake to out_valid.
    task automatic do_op(input bit w, input longint a, input longint b, input bit s, input int gap,
                         output longint prod, output longint pix, output int lat);
        int n;
        n = 0;
        while (!get_r(w) && n < 100) begin @(posedge clk); #1; n++; end
        if (!get_r(w)) chk("in_ready_timeout", 0, 1);
        set_in(w, 1'b1, a, b, s);
        @(posedge clk); #1;
        set_in(w, 1'b0, longint'($urandom), longint'($urandom), 1'($urandom_range(0, 1)));
        lat = 0;
        while (!get_ov(w) && lat < 50) begin @(posedge clk); #1; lat++; end
        repeat (gap) begin @(posedge clk); #1; end
        prod = get_p(w);
        pix  = get_x(w);
        set_ordy(w, 1'b1);
        @(posedge clk); #1;
        set_ordy(w, 1'b0);
    endtask

    typedef struct {
        bit          sgn;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] prod;
        logic [7:0]  pix;
    } vec_t;

    vec_t tv[10];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        longint gp, gx, ep, ex, ra, rb;
        int lat, aw, bw, fw, el;
        bit w, sg;

        tv[0] = '{1'b0, 8'd200, 8'h10, 16'h0C80, 8'd200};
        tv[1] = '{1'b0, 8'd255, 8'd255, 16'hFE01, 8'd255};
        tv[2] = '{1'b0, 8'd1,   8'h08, 16'd8,    8'd1};
        tv[3] = '{1'b1, 8'h80,  8'h80, 16'h4000, 8'd255};
        tv[4] = '{1'b1, 8'd100, 8'hF0, 16'hF9C0, 8'd0};
        tv[5] = '{1'b0, 8'd0,   8'hA5, 16'd0,    8'd0};
        tv[6] = '{1'b1, 8'h5A,  8'h00, 16'd0,    8'd0};
        tv[7] = '{1'b1, 8'h7F,  8'h80, 16'hC080, 8'd0};
        tv[8] = '{1'b1, 8'hFF,  8'hFF, 16'd1,    8'd0};
        tv[9] = '{1'b0, 8'd7,   8'd9,  16'd63,   8'd4};

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("rst_in_ready0", r0, 1);  chk("rst_out_valid0", ov0, 0);
        chk("rst_prod0", p0, 0);      chk("rst_pix0", x0, 0);
        chk("rst_in_ready1", r1, 1);  chk("rst_out_valid1", ov1, 0);

        for (int i = 0; i < 10; i++) begin
            do_op(1'b0, longint'(tv[i].a), longint'(tv[i].b), tv[i].sgn, i % 3, gp, gx, lat);
            chk("vec_prod", gp, longint'(tv[i].prod));
            chk("vec_pix", gx, longint'(tv[i].pix));
            chk("vec_latency", lat, 5);
        end

        // Backpressure: results held, busy input ignored.
        set_in(1'b0, 1'b1, 9, 11, 1'b0);
        @(posedge clk); #1;
        set_in(1'b0, 1'b0, 0, 0, 1'b0);
        lat = 0;
        while (!ov0 && lat < 50) begin @(posedge clk); #1; lat++; end
        chk("bp_latency", lat, 5);
        for (int c = 0; c < 10; c++) begin
            set_in(1'b0, 1'(c % 2), 50, 50, 1'b1);
            @(posedge clk); #1;
            chk("bp_valid", ov0, 1); chk("bp_prod", p0, 99);
            chk("bp_pix", x0, 6);    chk("bp_in_ready", r0, 0);
        end
        set_in(1'b0, 1'b0, 0, 0, 1'b0);
        or0 = 1'b1;
        @(posedge clk); #1;
        or0 = 1'b0;
        chk("bp_ready_after", r0, 1); chk("bp_valid_after", ov0, 0);
        chk("bp_prod_hold", p0, 99);  chk("bp_pix_hold", x0, 6);
        repeat (8) begin @(posedge clk); #1; end
        chk("bp_no_capture", ov0, 0);

        // Reset in the middle of iteration.
        set_in(1'b0, 1'b1, 200, 200, 1'b0);
        @(posedge clk); #1;
        set_in(1'b0, 1'b0, 0, 0, 1'b0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("midrst_in_ready", r0, 1); chk("midrst_valid", ov0, 0);
        chk("midrst_prod", p0, 0);     chk("midrst_pix", x0, 0);
        do_op(1'b0, 7, 9, 1'b0, 0, gp, gx, lat);
        chk("midrst_next_prod", gp, 63);
        chk("midrst_next_lat", lat, 5);

        // Randomized ops on both parameterizations.
        for (int k = 0; k < 3600; k++) begin
            w  = (k >= 2200);
            aw = w ? 12 : 8;
            bw = w ? 10 : 8;
            fw = w ? 6 : 4;
            el = w ? 6 : 5;
            sg = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 7))
                0:       ra = 0;
                1:       ra = (longint'(1) << aw) - 1;
                2:       ra = longint'(1) << (aw - 1);
                default: ra = longint'($urandom) & ((longint'(1) << aw) - 1);
            endcase
            case ($urandom_range(0, 7))
                0:       rb = 0;
                1:       rb = (longint'(1) << bw) - 1;
                2:       rb = longint'(1) << (bw - 1);
                default: rb = longint'($urandom) & ((longint'(1) << bw) - 1);
            endcase
            model(aw, bw, fw, ra, rb, sg, ep, ex);
            do_op(w, ra, rb, sg, $urandom_range(0, 3), gp, gx, lat);
            chk("rand_prod", gp, ep);
            chk("rand_pix", gx, ex);
            chk("rand_latency", lat, el);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
